// File: rtl/fprn_switch_sequencer.sv
// Break-before-make sequencer for the resistor-network analog switch matrix.
// A switch map is streamed in a byte at a time into a shadow register; a
// commit then opens the switches that must turn off, waits a settle time,
// closes the switches that must turn on, and waits a second settle time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | accepting map bytes and commits
// S_BREAK | only switches common to old and new map closed; settling
// S_MAKE  | new map applied to sw_en; settling before done
module fprn_switch_sequencer #(
    parameter int NUM_SW        = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              commit,
    input  logic              abort,
    output logic [NUM_SW-1:0] sw_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int NB = NUM_SW / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BREAK = 2'd1,
        S_MAKE  = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [NUM_SW-1:0] shadow;
    logic [IW-1:0]     idx;
    logic              full;

    logic is_idle;
    logic byte_acc;
    logic commit_req;
    logic commit_ok;
    logic commit_bad;

    // Handshake and commit qualification; commit is judged against the
    // current full flag, before any byte landing in the same cycle.
    // rst_n gates data_ready so it reads 0 while reset is held.
    always_comb begin
        is_idle    = (state == S_IDLE);
        data_ready = rst_n && ena && is_idle && !abort;
        byte_acc   = data_valid && data_ready;
        commit_req = commit && ena && !abort;
        commit_ok  = commit_req && is_idle && full;
        commit_bad = commit_req && !(is_idle && full);
    end

    // Map loading, sequencing FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            shadow <= '0;
            idx    <= '0;
            full   <= 1'b0;
            sw_en  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Emergency open: shadow and err deliberately kept.
                state <= S_IDLE;
                sw_en <= '0;
                busy  <= 1'b0;
                idx   <= '0;
                full  <= 1'b0;
            end else begin
                if (byte_acc) begin
                    for (int b = 0; b < NB; b++) begin
                        if (idx == IW'(b)) begin
                            shadow[8*b +: 8] <= data_in;
                        end
                    end
                    // A byte arriving on a full map restarts it, so full
                    // only stays set when this byte completes the map.
                    if (idx == IDX_LAST) begin
                        idx  <= '0;
                        full <= 1'b1;
                    end else begin
                        idx  <= idx + 1'b1;
                        full <= 1'b0;
                    end
                end
                if (commit_bad) begin
                    err <= 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        if (commit_ok) begin
                            sw_en <= sw_en & shadow;
                            cnt   <= CNT_LOAD;
                            busy  <= 1'b1;
                            full  <= 1'b0;
                            err   <= 1'b0;
                            state <= S_BREAK;
                        end
                    end
                    S_BREAK: begin
                        if (cnt == '0) begin
                            sw_en <= shadow;
                            cnt   <= CNT_LOAD;
                            state <= S_MAKE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_MAKE: begin
                        if (cnt == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fprn_switch_sequencer.sv
// Bench for fprn_switch_sequencer (NUM_SW=16, SETTLE_CYCLES=4).
module tb_fprn_switch_sequencer;

    localparam int NSW = 16;
    localparam int S   = 4;

    logic           clk;
    logic           rst_n;
    logic           ena;
    logic [7:0]     data_in;
    logic           data_valid;
    logic           data_ready;
    logic           commit;
    logic           abort;
    logic [NSW-1:0] sw_en;
    logic           busy;
    logic           done;
    logic           err;

    int tests;
    int fails;
    logic [NSW-1:0] m_sw;

    fprn_switch_sequencer #(.NUM_SW(NSW), .SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .commit     (commit),
        .abort      (abort),
        .sw_en      (sw_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    // Commit now and follow the whole sequence cycle by cycle; optional
    // stray commit / byte injected in cycle T+k (k<=0 disables).
    task automatic run_sequence(input logic [NSW-1:0] old_map, input logic [NSW-1:0] new_map,
                                input int inj_commit, input int inj_byte, input logic [7:0] inj_val);
        logic [NSW-1:0] exp_sw;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int k = 1; k <= 2*S+1; k++) begin
            exp_sw = (k <= S) ? (old_map & new_map) : new_map;
            tests++;
            if (sw_en !== exp_sw) begin
                fails++;
                $display("FAIL seq_sw_en T+%0d: got %h expected %h", k, sw_en, exp_sw);
            end
            tests++;
            if ((sw_en & ~(old_map | new_map)) !== '0) begin
                fails++;
                $display("FAIL seq_no_extra_close T+%0d: got %h allowed %h", k, sw_en, old_map | new_map);
            end
            tests++;
            if (busy !== (k <= 2*S)) begin
                fails++;
                $display("FAIL seq_busy T+%0d: got %b expected %b", k, busy, (k <= 2*S));
            end
            tests++;
            if (done !== (k == 2*S+1)) begin
                fails++;
                $display("FAIL seq_done T+%0d: got %b expected %b", k, done, (k == 2*S+1));
            end
            if (k == 1) begin
                tests++;
                if (err !== 1'b0) begin
                    fails++;
                    $display("FAIL seq_err_clear: got %b expected 0", err);
                end
            end
            if (k < 2*S+1) begin
                if (k == inj_commit) commit = 1'b1;
                if (k == inj_byte) begin
                    data_in    = inj_val;
                    data_valid = 1'b1;
                    tests++;
                    if (data_ready !== 1'b0) begin
                        fails++;
                        $display("FAIL busy_data_ready T+%0d: got %b expected 0", k, data_ready);
                    end
                end
                tick();
                commit     = 1'b0;
                data_valid = 1'b0;
            end
        end
        if (inj_commit > 0) begin
            tests++;
            if (err !== 1'b1) begin
                fails++;
                $display("FAIL busy_commit_err: got %b expected 1", err);
            end
        end
        m_sw = new_map;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        tick();
        tick();
        tests++;
        if (sw_en !== '0) begin fails++; $display("FAIL reset_sw_en: got %h expected 0000", sw_en); end
        tests++;
        if ({busy, done, err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {busy, done, err}); end
        tests++;
        if (data_ready !== 1'b0) begin fails++; $display("FAIL reset_data_ready: got %b expected 0", data_ready); end
        rst_n = 1'b1;
        tick();
        tests++;
        if (data_ready !== 1'b1) begin fails++; $display("FAIL idle_data_ready: got %b expected 1", data_ready); end
        m_sw = '0;
    endtask

    task automatic test_basic();
        load_byte(8'h0F);
        load_byte(8'hA5);
        run_sequence(m_sw, 16'hA50F, 0, 0, 8'h00);
    endtask

    task automatic test_break_make();
        load_byte(8'hF0);
        load_byte(8'h0F);
        run_sequence(m_sw, 16'h0FF0, 0, 0, 8'h00);
    endtask

    task automatic test_partial_map();
        load_byte(8'h33);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL partial_err: got %b expected 1", err); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL partial_busy: got %b expected 0", busy); end
        tests++;
        if (sw_en !== m_sw) begin fails++; $display("FAIL partial_sw_en: got %h expected %h", sw_en, m_sw); end
        load_byte(8'h44);
        run_sequence(m_sw, 16'h4433, 0, 0, 8'h00);
    endtask

    task automatic test_back_to_back_reject();
        load_byte(8'h81);
        load_byte(8'h7E);
        run_sequence(m_sw, 16'h7E81, 2, 6, 8'hEE);
        load_byte(8'h11);
        load_byte(8'h22);
        run_sequence(m_sw, 16'h2211, 0, 0, 8'h00);
    endtask

    task automatic test_abort();
        load_byte(8'h96);
        load_byte(8'h69);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tests++;
        if (data_ready !== 1'b0) begin fails++; $display("FAIL abort_data_ready: got %b expected 0", data_ready); end
        tick();
        abort = 1'b0;
        m_sw  = '0;
        tests++;
        if (sw_en !== '0) begin fails++; $display("FAIL abort_sw_en: got %h expected 0000", sw_en); end
        tests++;
        if ({busy, done, err} !== 3'b000) begin fails++; $display("FAIL abort_flags: got %b expected 000", {busy, done, err}); end
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if ({busy, done, sw_en} !== '0) begin
                fails++;
                $display("FAIL abort_quiet cycle %0d: busy %b done %b sw_en %h expected all 0", i, busy, done, sw_en);
            end
        end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tests++;
        if ({busy, err} !== 2'b01) begin fails++; $display("FAIL abort_recommit: busy/err got %b expected 01", {busy, err}); end
        load_byte(8'h5A);
        load_byte(8'hC3);
        run_sequence(m_sw, 16'hC35A, 0, 0, 8'h00);
    endtask

    task automatic test_random();
        logic [NSW-1:0] nm;
        for (int it = 0; it < 16; it++) begin
            nm = (it == 0) ? m_sw : NSW'($urandom);
            load_byte(nm[7:0]);
            load_byte(nm[15:8]);
            run_sequence(m_sw, nm, 0, 0, 8'h00);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic test_reset_mid_make();
        load_byte(8'h3C);
        load_byte(8'h5A);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (5) tick();
        tests++;
        if (sw_en !== 16'h5A3C) begin fails++; $display("FAIL mid_make_sw_en: got %h expected 5a3c", sw_en); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (sw_en !== '0) begin fails++; $display("FAIL async_reset_sw_en: got %h expected 0000", sw_en); end
        tests++;
        if ({busy, done, err, data_ready} !== 4'b0000) begin
            fails++;
            $display("FAIL async_reset_flags: got %b expected 0000", {busy, done, err, data_ready});
        end
        tick();
        rst_n = 1'b1;
        m_sw  = '0;
        ena        = 1'b0;
        data_in    = 8'h77;
        data_valid = 1'b1;
        commit     = 1'b1;
        tests++;
        if (data_ready !== 1'b0) begin fails++; $display("FAIL ena_low_data_ready: got %b expected 0", data_ready); end
        tick();
        data_valid = 1'b0;
        commit     = 1'b0;
        tests++;
        if ({busy, err} !== 2'b00) begin fails++; $display("FAIL ena_low_commit: busy/err got %b expected 00", {busy, err}); end
        ena = 1'b1;
        load_byte(8'h12);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tests++;
        if ({busy, err} !== 2'b01) begin fails++; $display("FAIL ena_low_byte_ignored: busy/err got %b expected 01", {busy, err}); end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        m_sw       = '0;
        rst_n      = 1'b0;
        ena        = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        commit     = 1'b0;
        abort      = 1'b0;
        test_reset();
        test_basic();
        test_break_make();
        test_partial_map();
        test_back_to_back_reject();
        test_abort();
        test_random();
        test_reset_mid_make();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
